output_arbiter: RTL
===================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 32'h20000: cycles o_READ_BUS is held; SHALL exceed one full divided-clock period of the display driver.
REQ-002 Parameter CLEAR_CYCLES, default 4: cycles o_CLEAR_n is held low; legal range 1..255.
REQ-003 i_SYS_CLOCK  in  1  system clock. The block uses one clock; reset is synchronous and active-high.
REQ-004 i_RESET  in  1  reset, synchronous, active-high.
REQ-005 i_REQ_0  in  1  requester 0 (CPU) write request.
REQ-006 i_DATA_0  in  24  requester 0 display value.
REQ-007 o_ACK_0  out  1  requester 0 completion pulse.
REQ-008 i_REQ_1  in  1  requester 1 (debug) write request.
REQ-009 i_DATA_1  in  24  requester 1 display value.
REQ-010 o_ACK_1  out  1  requester 1 completion pulse.
REQ-011 i_CLR_REQ  in  1  single-cycle display-clear strobe.
REQ-012 o_BUS  out  32  display bus value, {8'b0, latched data}.
REQ-013 o_READ_BUS  out  1  display load enable.
REQ-014 o_CLEAR_n  out  1  active-low display clear.
REQ-015 o_BUSY  out  1  high whenever the state is not IDLE.
REQ-016 o_OWNER  out  1  index of the last granted requester.

Function
REQ-017 The FSM SHALL have the states IDLE, HOLD, ACK and CLEAR; all outputs SHALL be decoded from registered state only.
REQ-018 In IDLE, a pending or arriving clear SHALL take priority: next state CLEAR, cycle counter = 0.
REQ-019 Otherwise, in IDLE with any i_REQ_x high, the block SHALL grant one requester, latch its i_DATA_x into r_DATA, set o_OWNER, and go to HOLD with counter = 0.
REQ-020 Arbitration SHALL be round-robin via pointer r_PRIO: if both requests are high, r_PRIO's requester wins; after any grant, r_PRIO becomes the non-granted index.
REQ-021 In HOLD, o_READ_BUS SHALL be 1 and o_BUS SHALL stay stable for exactly HOLD_CYCLES cycles (counter 0..HOLD_CYCLES-1), then the FSM SHALL go to ACK.
REQ-022 In ACK, the owner's o_ACK_x SHALL be 1 for exactly one cycle, o_READ_BUS SHALL be 0, and the next state SHALL be IDLE.
REQ-023 Latency: a request seen in IDLE at cycle t SHALL give o_READ_BUS high over t+1..t+HOLD_CYCLES and o_ACK at t+HOLD_CYCLES+1; the earliest next grant SHALL be at t+HOLD_CYCLES+2.
REQ-024 Handshake: the requester SHALL hold i_REQ_x and i_DATA_x until o_ACK_x; data changes after the grant are ignored. An i_REQ_x still high in the cycle after ACK is a new request.
REQ-025 In CLEAR, o_CLEAR_n SHALL be 0 for exactly CLEAR_CYCLES cycles; the FSM SHALL then return to IDLE with no ACK pulse.
REQ-026 An i_CLR_REQ arriving in HOLD, ACK or CLEAR SHALL set r_CLR_PEND; multiple strobes SHALL collapse into one; r_CLR_PEND SHALL be cleared on entry to CLEAR.
REQ-027 An i_CLR_REQ in IDLE coinciding with a write request SHALL win; the write request waits.
REQ-028 A write in progress SHALL never be aborted by a clear; the clear runs after ACK.
REQ-029 The counter SHALL be 32 bits and SHALL not wrap within any state.

Reset
REQ-030 When i_RESET = 1 at a clock edge, the block SHALL set state = IDLE, counter = 0, r_DATA = 0, r_PRIO = 0, r_CLR_PEND = 0, and o_OWNER = 0, whatever the current state.
REQ-031 While reset is applied and after it: o_BUS = 0, o_READ_BUS = 0, o_CLEAR_n = 1, o_ACK_0 = o_ACK_1 = 0, o_BUSY = 0.
REQ-032 Reset SHALL NOT issue a display clear; the displayed value is retained.

Structure
REQ-033 Package output_ctrl_pkg SHALL hold the state encoding, the HOLD_CYCLES and CLEAR_CYCLES defaults, and the data width of 24.
REQ-034 The two-way round-robin grant logic SHALL be a sub-module arb_rr2 (inputs req[1:0] and prio; outputs grant[1:0]); the FSM stays in output_arbiter.

Verification (HOLD_CYCLES=8, CLEAR_CYCLES=4)
REQ-035 Single write: REQ_0 with DATA_0=24'h123456 at t -> READ_BUS high t+1..t+8, o_BUS=32'h00123456, ACK_0 at t+9 only.
REQ-036 Contention: REQ_0 and REQ_1 both held after reset -> grant order 0,1,0,1; OWNER toggles; each ACK is one cycle.
REQ-037 Clear vs write: CLR_REQ and REQ_1 in the same IDLE cycle -> CLEAR_n low 4 cycles, then the write to requester 1, then ACK_1.
REQ-038 Clear during HOLD: three CLR_REQ strobes mid-HOLD -> write completes with ACK, then exactly one 4-cycle CLEAR_n pulse.
REQ-039 Reset mid-HOLD: i_RESET at counter=5 -> next cycle READ_BUS=0, BUSY=0, no ACK; a fresh request is then granted normally with r_PRIO=0.
REQ-040 Data stability: change DATA_0 to 24'hFFFFFF during HOLD -> o_BUS keeps the latched value until ACK.

Source files
------------

// File: rtl/output_ctrl_pkg.sv
// Shared types and defaults for the display output arbiter: state encoding,
// timing defaults and the display data width.
package output_ctrl_pkg;

    localparam int DATA_W = 24;
    localparam int BUS_W  = 32;

    localparam int unsigned HOLD_CYCLES_DEF  = 32'h20000;
    localparam int unsigned CLEAR_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ACK   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Display bus carries the 24-bit value zero-extended to 32 bits.
    function automatic logic [BUS_W-1:0] pad_bus(input logic [DATA_W-1:0] data);
        return {{(BUS_W - DATA_W){1'b0}}, data};
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Requester / display-side signal bundle of the output arbiter.
// master = requesters and display, slave = the arbiter itself.
interface output_arbiter_if;
    import output_ctrl_pkg::*;

    logic              i_REQ_0;
    logic [DATA_W-1:0] i_DATA_0;
    logic              o_ACK_0;
    logic              i_REQ_1;
    logic [DATA_W-1:0] i_DATA_1;
    logic              o_ACK_1;
    logic              i_CLR_REQ;
    logic [BUS_W-1:0]  o_BUS;
    logic              o_READ_BUS;
    logic              o_CLEAR_n;
    logic              o_BUSY;
    logic              o_OWNER;

    modport master (
        output i_REQ_0, i_DATA_0, i_REQ_1, i_DATA_1, i_CLR_REQ,
        input  o_ACK_0, o_ACK_1, o_BUS, o_READ_BUS, o_CLEAR_n, o_BUSY, o_OWNER
    );

    modport slave (
        input  i_REQ_0, i_DATA_0, i_REQ_1, i_DATA_1, i_CLR_REQ,
        output o_ACK_0, o_ACK_1, o_BUS, o_READ_BUS, o_CLEAR_n, o_BUSY, o_OWNER
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: a lone request wins outright, on contention
// the requester named by prio wins. Purely combinational, one-hot grant.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req[gi] & (~req[1 - gi] | (prio == 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/output_arbiter.sv
// Arbitrates two display writers and a clear strobe onto one display bus,
// holding each write for HOLD_CYCLES and each clear for CLEAR_CYCLES.
module output_arbiter
    import output_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic          i_SYS_CLOCK,
    input  logic          i_RESET,
    output_arbiter_if.slave bus
);

    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_CYCLES - 1);

    state_t            state_reg;
    logic [31:0]       cnt_reg;
    logic [31:0]       cnt_next;
    logic [DATA_W-1:0] data_reg;
    logic              prio_reg;
    logic              clr_pend_reg;
    logic              owner_reg;

    logic [1:0]        req_vec;
    logic [1:0]        grant_vec;
    logic              grant_idx;
    logic [1:0]        ack_vec;

    assign req_vec   = {bus.i_REQ_1, bus.i_REQ_0};
    assign grant_idx = grant_vec[1];

    arb_rr2 u_arb (
        .req   (req_vec),
        .prio  (prio_reg),
        .grant (grant_vec)
    );

    // Saturating increment so the counter can never wrap inside a state.
    assign cnt_next = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            data_reg     <= '0;
            prio_reg     <= 1'b0;
            clr_pend_reg <= 1'b0;
            owner_reg    <= 1'b0;
        end else begin
            // Clear strobes seen while busy are remembered (collapsed) and
            // serviced at the next IDLE, so a write is never cut short.
            if (state_reg != ST_IDLE && bus.i_CLR_REQ) begin
                clr_pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (bus.i_CLR_REQ || clr_pend_reg) begin
                        state_reg    <= ST_CLEAR;
                        clr_pend_reg <= 1'b0;
                    end else if (|grant_vec) begin
                        state_reg <= ST_HOLD;
                        owner_reg <= grant_idx;
                        prio_reg  <= ~grant_idx;
                        data_reg  <= grant_idx ? bus.i_DATA_1 : bus.i_DATA_0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg <= ST_ACK;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
                ST_CLEAR: begin
                    if (cnt_reg == CLEAR_LAST) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == ST_ACK) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign bus.o_ACK_0    = ack_vec[0];
    assign bus.o_ACK_1    = ack_vec[1];
    assign bus.o_BUS      = pad_bus(data_reg);
    assign bus.o_READ_BUS = (state_reg == ST_HOLD);
    assign bus.o_CLEAR_n  = (state_reg != ST_CLEAR);
    assign bus.o_BUSY     = (state_reg != ST_IDLE);
    assign bus.o_OWNER    = owner_reg;

endmodule
